// File: rtl/input_debouncer.sv
// input_debouncer
// Multi-channel input conditioner: each raw input is synchronised, then
// debounced by a per-channel saturating stability counter gated by 'tick'.
// Registered one-cycle rise/fall pulses accompany every change of 'op'.
// Optional fast-release mode lets 1->0 transitions bypass the debounce.

module input_debouncer #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 6,
    parameter int                  CNT_WIDTH       = 8,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}},
    parameter bit                  FAST_RELEASE    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ip,
    input  logic                tick,
    output logic [CHANNELS-1:0] op,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("input_debouncer: SYNC_STAGES must be in 2..4");
    end

    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_debounce
        $error("input_debouncer: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_WIDTH bits");
    end

    // Terminal count: the qualifying tick that sees this value commits the new level.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Per-channel synchroniser, stability counter and edge pulses.
    // Channels share nothing except clk, rst and tick.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_s;
        logic [CNT_WIDTH-1:0]   cnt_q;
        logic [CNT_WIDTH-1:0]   cnt_d;
        logic                   op_q;
        logic                   op_d;
        logic                   rise_q;
        logic                   fall_q;

        // Plain shift chain; nothing sits between the stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= {SYNC_STAGES{RESET_VALUE[gi]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], ip[gi]};
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];

        // Next-state for the stable level and its counter, highest priority first.
        always_comb begin
            cnt_d = cnt_q;
            op_d  = op_q;
            if (sync_s == op_q) begin
                // Input agrees with the stable level: any partial count was a glitch.
                cnt_d = '0;
            end else if (FAST_RELEASE == 1'b1 && op_q == 1'b1 && sync_s == 1'b0) begin
                // Legacy release path: drop immediately, independent of tick.
                op_d  = 1'b0;
                cnt_d = '0;
            end else if (tick && cnt_q == CNT_LAST) begin
                // New level has held long enough: commit it and restart counting.
                op_d  = sync_s;
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // tick low with a mismatch: count is held, not cleared.
        end

        // Stable level, counter and registered edge pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                op_q   <= RESET_VALUE[gi];
                cnt_q  <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                op_q   <= op_d;
                cnt_q  <= cnt_d;
                rise_q <= op_d & ~op_q;
                fall_q <= ~op_d & op_q;
            end
        end

        assign op[gi]   = op_q;
        assign rise[gi] = rise_q;
        assign fall[gi] = fall_q;
    end

endmodule
